// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an IMG_W x IMG_H image from IROM, applies
// 2x2-window commands around a movable origin, and streams the result to IRAM.
module lcd_ctrl_param #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned SW = DW + 2;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          irom_rd_q, irom_rd_d;
    logic [AW-1:0] irom_a_q, irom_a_d;
    logic          iram_valid_q, iram_valid_d;
    logic [AW-1:0] iram_a_q, iram_a_d;
    logic [DW-1:0] iram_d_q, iram_d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    cmd_q, cmd_d;

    logic [DW-1:0] pix_q [N];

    // Window addressing: power-of-two sizes make row*IMG_W+col a plain concatenation
    logic [XW-1:0] xl_c;
    logic [YW-1:0] yu_c;
    logic [AW-1:0] idx_tl_c, idx_tr_c, idx_bl_c, idx_br_c;
    logic [DW-1:0] p_tl_c, p_tr_c, p_bl_c, p_br_c;

    assign xl_c     = x_q - XW'(1);
    assign yu_c     = y_q - YW'(1);
    assign idx_tl_c = {yu_c, xl_c};
    assign idx_tr_c = {yu_c, x_q};
    assign idx_bl_c = {y_q, xl_c};
    assign idx_br_c = {y_q, x_q};
    assign p_tl_c   = pix_q[idx_tl_c];
    assign p_tr_c   = pix_q[idx_tr_c];
    assign p_bl_c   = pix_q[idx_bl_c];
    assign p_br_c   = pix_q[idx_br_c];

    logic [DW-1:0] max_t_c, max_b_c, max_c, min_t_c, min_b_c, min_c, avg_c;
    logic [SW-1:0] sum_c;

    assign max_t_c = (p_tl_c > p_tr_c) ? p_tl_c : p_tr_c;
    assign max_b_c = (p_bl_c > p_br_c) ? p_bl_c : p_br_c;
    assign max_c   = (max_t_c > max_b_c) ? max_t_c : max_b_c;
    assign min_t_c = (p_tl_c < p_tr_c) ? p_tl_c : p_tr_c;
    assign min_b_c = (p_bl_c < p_br_c) ? p_bl_c : p_br_c;
    assign min_c   = (min_t_c < min_b_c) ? min_t_c : min_b_c;
    assign sum_c   = SW'(p_tl_c) + SW'(p_tr_c) + SW'(p_bl_c) + SW'(p_br_c);
    assign avg_c   = DW'(sum_c >> 2);

    logic          load_we_c, win_we_c;
    logic [DW-1:0] n_tl_c, n_tr_c, n_bl_c, n_br_c;

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            irom_rd_q    <= 1'b1;
            irom_a_q     <= '0;
            iram_valid_q <= 1'b0;
            iram_a_q     <= '0;
            iram_d_q     <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            x_q          <= XW'(IMG_W / 2);
            y_q          <= YW'(IMG_H / 2);
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            irom_rd_q    <= irom_rd_d;
            irom_a_q     <= irom_a_d;
            iram_valid_q <= iram_valid_d;
            iram_a_q     <= iram_a_d;
            iram_d_q     <= iram_d_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cmd_q        <= cmd_d;
        end
    end

    // Pixel array is not reset; a reload overwrites it
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_we_c) begin
                pix_q[irom_a_q] <= IROM_Q;
            end
            if (win_we_c) begin
                pix_q[idx_tl_c] <= n_tl_c;
                pix_q[idx_tr_c] <= n_tr_c;
                pix_q[idx_bl_c] <= n_bl_c;
                pix_q[idx_br_c] <= n_br_c;
            end
        end
    end

    // Next-state, command execution and output sequencing
    always_comb begin
        state_d      = state_q;
        irom_rd_d    = irom_rd_q;
        irom_a_d     = irom_a_q;
        iram_valid_d = iram_valid_q;
        iram_a_d     = iram_a_q;
        iram_d_d     = iram_d_q;
        busy_d       = busy_q;
        done_d       = done_q;
        x_d          = x_q;
        y_d          = y_q;
        cmd_d        = cmd_q;
        load_we_c    = 1'b0;
        win_we_c     = 1'b0;
        n_tl_c       = p_tl_c;
        n_tr_c       = p_tr_c;
        n_bl_c       = p_bl_c;
        n_br_c       = p_br_c;

        case (state_q)
            S_LOAD: begin
                load_we_c = 1'b1;
                irom_a_d  = irom_a_q + AW'(1);
                if (irom_a_q == AW'(N - 1)) begin
                    irom_rd_d = 1'b0;
                    irom_a_d  = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cmd_valid && !busy_q) begin
                    cmd_d  = cmd;
                    busy_d = 1'b1;
                    if (cmd == 4'd0) begin
                        iram_valid_d = 1'b1;
                        iram_a_d     = '0;
                        iram_d_d     = pix_q[0];
                        state_d      = S_WRITE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                case (cmd_q)
                    4'd1: if (y_q > YW'(1)) y_d = y_q - YW'(1);
                    4'd2: if (y_q < YW'(IMG_H - 1)) y_d = y_q + YW'(1);
                    4'd3: if (x_q > XW'(1)) x_d = x_q - XW'(1);
                    4'd4: if (x_q < XW'(IMG_W - 1)) x_d = x_q + XW'(1);
                    4'd5: begin
                        win_we_c = 1'b1;
                        n_tl_c   = max_c;
                        n_tr_c   = max_c;
                        n_bl_c   = max_c;
                        n_br_c   = max_c;
                    end
                    4'd6: begin
                        win_we_c = 1'b1;
                        n_tl_c   = min_c;
                        n_tr_c   = min_c;
                        n_bl_c   = min_c;
                        n_br_c   = min_c;
                    end
                    4'd7: begin
                        win_we_c = 1'b1;
                        n_tl_c   = avg_c;
                        n_tr_c   = avg_c;
                        n_bl_c   = avg_c;
                        n_br_c   = avg_c;
                    end
                    4'd8: begin
                        win_we_c = 1'b1;
                        n_tl_c   = p_tr_c;
                        n_tr_c   = p_br_c;
                        n_br_c   = p_bl_c;
                        n_bl_c   = p_tl_c;
                    end
                    4'd9: begin
                        win_we_c = 1'b1;
                        n_tl_c   = p_bl_c;
                        n_bl_c   = p_br_c;
                        n_br_c   = p_tr_c;
                        n_tr_c   = p_tl_c;
                    end
                    4'd10: begin
                        win_we_c = 1'b1;
                        n_tl_c   = p_bl_c;
                        n_bl_c   = p_tl_c;
                        n_tr_c   = p_br_c;
                        n_br_c   = p_tr_c;
                    end
                    4'd11: begin
                        win_we_c = 1'b1;
                        n_tl_c   = p_tr_c;
                        n_tr_c   = p_tl_c;
                        n_bl_c   = p_br_c;
                        n_br_c   = p_bl_c;
                    end
                    4'd12: begin
                        x_d = XW'(IMG_W / 2);
                        y_d = YW'(IMG_H / 2);
                    end
                    default: ;
                endcase
            end
            S_WRITE: begin
                if (iram_a_q == AW'(N - 1)) begin
                    iram_valid_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    iram_a_d = iram_a_q + AW'(1);
                    iram_d_d = pix_q[iram_a_q + AW'(1)];
                end
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign IROM_rd    = irom_rd_q;
    assign IROM_A     = irom_a_q;
    assign IRAM_valid = iram_valid_q;
    assign IRAM_A     = iram_a_q;
    assign IRAM_D     = iram_d_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
- Parametrised image-processing controller for the LCD datapath.
- Loads an IMG_W x IMG_H image of DW-bit pixels from IROM into an internal pixel array.
- Applies 2x2-window commands (shift, max, min, average, rotate, mirror, recentre) under a cmd_valid/busy handshake.
- Streams the result to IRAM on the write command.
- Successor to the fixed 8x8/8-bit controller: arbitrary rectangular size, defined handshake, defined rounding, extra recentre command.

Parameters:
IMG_W, 8, image width in pixels (power of 2, >=4)
IMG_H, 8, image height in pixels (power of 2, >=4)
DW, 8, pixel width in bits
AW, $clog2(IMG_W*IMG_H), pixel address width (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd  in  4  command code
cmd_valid  in  1  cmd is valid this cycle
IROM_Q  in  DW  ROM read data for current IROM_A (asynchronous ROM, valid same cycle)
IROM_rd  out  1  ROM read enable
IROM_A  out  AW  ROM address
IRAM_valid  out  1  IRAM write strobe
IRAM_D  out  DW  IRAM write data
IRAM_A  out  AW  IRAM write address
busy  out  1  controller cannot accept a command
done  out  1  image write-out complete (sticky)

Behaviour:
- Single clock; reset is synchronous and active-high. Ports named clk and reset.
- Reset values: IROM_rd=1, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, busy=1, done=0; state=LOAD; origin x=IMG_W/2, y=IMG_H/2.
- Pixel index = row*IMG_W + col. Window relative to origin (x,y):
  - TL=(x-1,y-1), TR=(x,y-1), BL=(x-1,y), BR=(x,y).
  - x ranges 1..IMG_W-1; y ranges 1..IMG_H-1.
- States:
  - LOAD: each cycle capture IROM_Q into pixel[IROM_A] and increment IROM_A. At the capture of address N-1 (N=IMG_W*IMG_H): IROM_rd->0, IROM_A->0, busy->0, go IDLE. Load takes exactly N cycles after reset release.
  - IDLE: command accepted only on an edge with cmd_valid=1 and busy=0.
    - On accept, register cmd and set busy=1.
    - cmd 0 -> WRITE; any other cmd -> EXEC.
    - cmd_valid while busy=1 is ignored, not queued.
  - EXEC (one cycle): apply the registered cmd, busy->0, return to IDLE. Net effect: busy is high exactly one cycle per non-write command.
  - WRITE: IRAM_valid=1 for N consecutive cycles, IRAM_A=0..N-1, IRAM_D=pixel[IRAM_A] in the same cycle. After the N-th write: IRAM_valid=0, done=1, go DONE.
  - DONE: busy=1 and done=1 held until reset; all commands ignored.
- Commands:
  - 1 up: y-1, saturate at 1. 2 down: y+1, saturate at IMG_H-1.
  - 3 left: x-1, saturate at 1. 4 right: x+1, saturate at IMG_W-1.
  - 5 max: all four window pixels <= max of the four.
  - 6 min: all four window pixels <= min of the four.
  - 7 avg: sum the four in DW+2 bits, floor divide by 4 (truncate); write to all four.
  - 8 rotate CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 9 rotate CW: TL<=BL, BL<=BR, BR<=TR, TR<=TL.
  - 10 mirror X: swap rows (TL<->BL, TR<->BR).
  - 11 mirror Y: swap columns (TL<->TR, BL<->BR).
  - 12 recentre: x=IMG_W/2, y=IMG_H/2.
  - 13-15 reserved: no-op, still busy for one cycle.
- Window ops read all four old values before writing (no read-after-write within the op).
- Saturated shifts still take the EXEC cycle.
- Reset asserted in any state aborts the current state and restarts LOAD from address 0. Pixel array contents are not reset; they are overwritten by the reload.

Test Plan:
- Default params, ROM pixel=address -> IROM_A steps 0..63; busy falls after 64 load cycles; then cmd 0 -> IRAM sees A=k, D=k for k=0..63, then done=1 with busy held 1.
- Cmd 5 at origin (4,4) (window 27,28,35,36) -> pixels 27,28,35,36 all =36. After reload, cmd 7 -> all four =31 (126/4 truncated).
- Cmd 8 at origin -> pixel27=28, pixel28=36, pixel36=35, pixel35=27. A following cmd 9 restores the original values.
- Issue cmd 3 five times -> x saturates at 1. Cmd 5 -> window 24,25,32,33 all =33. Cmd 12 -> origin back to (4,4).
- cmd_valid held high through the EXEC cycle with a different cmd -> second cmd ignored. busy pattern is 1 for one cycle, then 0.
- IMG_W=16, IMG_H=4, DW=10, ROM=address -> origin (8,2), window 23,24,39,40. Cmd 6 -> all four =23. Mid-load reset at IROM_A=30 -> IROM_A restarts at 0 and load completes 64 cycles after reset release.
